// File: rtl/router_pkg.sv
// Shared types and header field layout for the router output reader.
package router_pkg;
  typedef enum logic [1:0] {
    ST_HDR     = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_PARITY  = 2'd2
  } state_e;

  localparam int LEN_MSB     = 7;
  localparam int LEN_LSB     = 2;
  localparam int ADDR_W      = 2;
  localparam int LEN_W       = LEN_MSB - LEN_LSB + 1;
  localparam int DEF_TIMEOUT = 30;

  function automatic logic [LEN_W-1:0] hdr_len(input logic [7:0] hdr);
    return hdr[LEN_MSB:LEN_LSB];
  endfunction
endpackage

// File: rtl/router_timeout.sv
// Counts cycles where data waits unread; raises a one-cycle flush after TIMEOUT of them.
module router_timeout
  import router_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic vld,
  input  logic rd,
  output logic flush
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Flush fires from the registered count, so it lands the cycle after the limit is hit.
  assign flush = (cnt_q == CW'(TIMEOUT));

  always_comb begin
    cnt_d = cnt_q;
    if (flush || rd || !vld) cnt_d = '0;
    else if (cnt_q != CW'(TIMEOUT)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/router_out_reader.sv
// Drains a router FIFO to the destination, parses header/payload/parity and flushes on stall timeout.
module router_out_reader
  import router_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_dout,
  output logic       fifo_rd_en,
  output logic       fifo_soft_reset,
  input  logic       read_enb,
  output logic       vld_out,
  output logic [7:0] data_out,
  output logic       data_out_vld,
  output logic       pkt_done,
  output logic       parity_err,
  output logic       pkt_drop
);
  state_e           state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [7:0]       acc_q, acc_d;
  logic [7:0]       hold_q;
  logic             rd_q;
  logic             beat;

  assign vld_out    = ~fifo_empty;
  assign fifo_rd_en = reset & read_enb & ~fifo_empty & ~fifo_soft_reset;
  assign pkt_drop   = fifo_soft_reset;

  // A byte arriving in a flush cycle belongs to the dropped packet.
  assign beat         = rd_q & ~fifo_soft_reset;
  assign data_out_vld = beat;
  assign data_out     = beat ? fifo_dout : hold_q;
  assign pkt_done     = beat & (state_q == ST_PARITY);
  assign parity_err   = pkt_done & (fifo_dout != acc_q);

  router_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk   (clk),
    .reset (reset),
    .vld   (vld_out),
    .rd    (read_enb),
    .flush (fifo_soft_reset)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    if (fifo_soft_reset) begin
      state_d = ST_HDR;
      rem_d   = '0;
      acc_d   = '0;
    end else if (rd_q) begin
      case (state_q)
        ST_HDR: begin
          rem_d   = hdr_len(fifo_dout);
          acc_d   = fifo_dout;
          state_d = (hdr_len(fifo_dout) != '0) ? ST_PAYLOAD : ST_PARITY;
        end
        ST_PAYLOAD: begin
          acc_d = acc_q ^ fifo_dout;
          rem_d = rem_q - 1'b1;
          if (rem_q == LEN_W'(1)) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          acc_d   = '0;
          rem_d   = '0;
          state_d = ST_HDR;
        end
        default: begin
          acc_d   = '0;
          rem_d   = '0;
          state_d = ST_HDR;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_HDR;
      rem_q   <= '0;
      acc_q   <= '0;
      rd_q    <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      acc_q   <= acc_d;
      rd_q    <= fifo_rd_en;
      if (beat) hold_q <= fifo_dout;
    end
  end
endmodule
